mem_port_arbiter: RTL and testbench

//  - Shares one data-memory port between instruction fetch (IF) and load/store (D).
//  - Sits between the CPU core and the data-memory macro, ahead of the multicycle core.
//  - Arbitrates requests, registers the winning request and drives the memory for one cycle.
//  - Waits a fixed read latency, then returns data or a write-ack to the winner.

---
 rtl/cpu_mem_pkg.sv | 6 +
 rtl/arb_pick_2.sv | 15 +
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared arbiter state/owner types and the fetch memory-op code
package cpu_mem_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;
  localparam logic [2:0] MEMOP_WORD = 3'b010;
endpackage

// File: rtl/arb_pick_2.sv
// arb_pick_2: two-way picker, D over IF or round-robin against the last winner
module arb_pick_2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       rr_en,
  output logic [1:0] gnt
);
  // D wins when alone, under fixed priority, or when IF won last time
  always_comb begin
    gnt[1] = req[1] & (~req[0] | ~rr_en | (last == OWN_IF));
    gnt[0] = req[0] & ~gnt[1];
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store; ARB_RR_EN selects round-robin
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_memop,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
`ifdef ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]    gnt;
  logic          idle, issue, done;
  assign idle  = state_q == ARB_IDLE;
  assign issue = state_q == ARB_ISSUE;
  assign done  = (state_q == ARB_WAIT) && (cnt_q == 4'd0);
  // owner_q doubles as last winner: it changes exactly on every grant
  arb_pick_2 u_pick (
    .req  ({d_req, if_req} & {2{idle & ~rst}}),
    .last (owner_q),
    .rr_en(RR_EN),
    .gnt  (gnt)
  );
  assign if_gnt    = gnt[0];
  assign d_gnt     = gnt[1];
  assign mem_en    = issue;
  assign mem_we    = issue & we_q;
  assign mem_addr  = issue ? addr_q : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign mem_op    = issue ? op_q : 3'b000;
  assign busy      = ~idle;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  // sequencing, request latch on grant, response capture when the wait expires
  always_comb begin
    state_d     = idle ? (|gnt ? ARB_ISSUE : ARB_IDLE) : issue ? ARB_WAIT : (done ? ARB_IDLE : ARB_WAIT);
    owner_d     = |gnt ? (gnt[1] ? OWN_D : OWN_IF) : owner_q;
    we_d        = |gnt ? gnt[1] & d_we : we_q;
    addr_d      = |gnt ? (gnt[1] ? d_addr : if_addr) : addr_q;
    wdata_d     = |gnt ? (gnt[1] ? d_wdata : '0) : wdata_q;
    op_d        = |gnt ? (gnt[1] ? d_memop : MEMOP_WORD) : op_q;
    cnt_d       = issue ? LAT_M1 : (state_q == ARB_WAIT ? cnt_q - 4'd1 : cnt_q);
    if_rvalid_d = done & (owner_q == OWN_IF);
    d_rvalid_d  = done & (owner_q == OWN_D);
    if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
    d_rdata_d   = d_rvalid_d ? (we_q ? '0 : mem_rdata) : d_rdata_q;
  end
  // state registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= 3'b000;
      cnt_q       <= 4'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at MEM_LAT 1 and 4; ARB_RR_EN aware
module tb_mem_port_arbiter;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0] d_memop;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_op;
  logic b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [2:0] b_mem_op;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_memop(d_memop), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_op(mem_op),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  mem_port_arbiter #(.MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_memop(d_memop), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_op(b_mem_op),
    .mem_rdata(mem_rdata), .busy(b_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic nc;
    @(negedge clk);
    mem_rdata = JUNK;
  endtask
  task automatic drop;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_memop = 0;
  endtask
  task automatic do_reset;
    nc(); rst = 1; drop(); nc(); rst = 0;
  endtask
  task automatic no_rvalid(input string tag);
    for (int i = 0; i < 8; i++) begin
      nc(); #1;
      check(tag, 32'({if_rvalid, d_rvalid, b_if_rvalid, b_d_rvalid}), 0);
    end
  endtask
  initial begin
    drop(); mem_rdata = JUNK;
    repeat (3) nc();
    rst = 0;
    // idle after reset
    for (int i = 0; i < 20; i++) begin
      nc(); #1;
      check("idle", 32'({busy, mem_en, if_gnt, d_gnt, if_rvalid, d_rvalid, b_busy, b_mem_en}), 0);
    end
    // fetch, MEM_LAT=1
    nc(); if_req = 1; if_addr = 32'h10; #1;
    check("if_gnt", 32'(if_gnt), 1); check("if_d_gnt", 32'(d_gnt), 0);
    nc(); drop(); #1;
    check("if_mem_en", 32'(mem_en), 1); check("if_mem_addr", mem_addr, 32'h10);
    check("if_mem_op", 32'(mem_op), 2); check("if_mem_we", 32'(mem_we), 0);
    nc(); mem_rdata = 32'h13; #1;
    check("if_mem_en_off", 32'(mem_en), 0); check("if_rvalid_early", 32'(if_rvalid), 0);
    nc(); #1;
    check("if_rvalid", 32'(if_rvalid), 1); check("if_rdata", if_rdata, 32'h13); check("if_busy", 32'(busy), 0);
    nc(); #1;
    check("if_rvalid_pulse", 32'(if_rvalid), 0); check("if_rdata_hold", if_rdata, 32'h13);
    // contention, D load first then IF on D's rvalid cycle
    do_reset();
    nc(); if_req = 1; if_addr = 32'h20; d_req = 1; d_addr = 32'h40; d_memop = 3'b100; #1;
    check("ca_d_gnt", 32'(d_gnt), 1); check("ca_if_gnt0", 32'(if_gnt), 0);
    nc(); d_req = 0; d_addr = 0; d_memop = 0; #1;
    check("ca_mem_addr", mem_addr, 32'h40); check("ca_mem_op", 32'(mem_op), 4); check("ca_busy_gnt", 32'(if_gnt), 0);
    nc(); mem_rdata = 32'h77; #1;
    check("ca_wait_gnt", 32'(if_gnt), 0);
    nc(); #1;
    check("ca_d_rvalid", 32'(d_rvalid), 1); check("ca_d_rdata", d_rdata, 32'h77); check("ca_if_gnt", 32'(if_gnt), 1);
    nc(); drop(); #1;
    check("ca_if_addr", mem_addr, 32'h20); check("ca_if_op", 32'(mem_op), 2);
    nc(); mem_rdata = 32'h99;
    nc(); #1;
    check("ca_if_rvalid", 32'(if_rvalid), 1); check("ca_if_rdata", if_rdata, 32'h99); check("ca_d_hold", d_rdata, 32'h77);
    // store
    nc(); d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_memop = 3'b010; #1;
    check("st_gnt", 32'(d_gnt), 1);
    nc(); drop(); #1;
    check("st_en", 32'(mem_en), 1); check("st_we", 32'(mem_we), 1); check("st_addr", mem_addr, 32'h100);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF); check("st_op", 32'(mem_op), 2);
    nc(); mem_rdata = 32'h5555_5555; #1;
    check("st_en_off", 32'({mem_en, mem_we}), 0);
    nc(); #1;
    check("st_rvalid", 32'(d_rvalid), 1); check("st_rdata", d_rdata, 0); check("st_if_rvalid", 32'(if_rvalid), 0);
    // contention with both requests held
    do_reset();
    nc(); if_req = 1; if_addr = 32'h30; d_req = 1; d_addr = 32'h50; #1;
    check("cb_first", 32'(d_gnt), 1);
    nc(); nc();
    nc(); #1;
    check("cb_rvalid", 32'(d_rvalid), 1);
    check("cb_if_gnt", 32'(if_gnt), 32'(RR)); check("cb_d_gnt", 32'(d_gnt), 32'(!RR));
    // MEM_LAT=4 load
    do_reset();
    nc(); d_req = 1; d_addr = 32'h60; #1;
    check("l4_gnt", 32'(b_d_gnt), 1);
    nc(); drop(); #1;
    check("l4_en", 32'(b_mem_en), 1); check("l4_addr", b_mem_addr, 32'h60); check("l4_busy1", 32'(b_busy), 1);
    for (int c = 2; c <= 5; c++) begin
      nc(); if (c == 5) mem_rdata = 32'hAB; #1;
      check("l4_wait", 32'({b_busy, b_mem_en, b_d_rvalid}), 32'b100);
    end
    nc(); #1;
    check("l4_rvalid", 32'(b_d_rvalid), 1); check("l4_rdata", b_d_rdata, 32'hAB); check("l4_busy_off", 32'(b_busy), 0);
    nc(); #1;
    check("l4_pulse", 32'(b_d_rvalid), 0);
    // reset during ISSUE drops mem_en without a clock edge
    do_reset();
    nc(); if_req = 1; if_addr = 32'h10;
    nc(); drop(); #1;
    check("ri_en", 32'(mem_en), 1);
    rst = 1; #1;
    check("ri_async", 32'({mem_en, busy, b_mem_en, b_busy}), 0); check("ri_addr", mem_addr, 0);
    nc(); rst = 0;
    no_rvalid("ri_no_rvalid");
    // reset during WAIT on the long-latency instance, then a normal access
    nc(); d_req = 1; d_addr = 32'h70;
    nc(); drop();
    nc(); nc(); #1;
    check("rw_busy", 32'(b_busy), 1);
    rst = 1; #1;
    check("rw_async", 32'({b_busy, b_mem_en, b_d_rvalid}), 0);
    nc(); rst = 0;
    no_rvalid("rw_no_rvalid");
    nc(); d_req = 1; d_addr = 32'h80; #1;
    check("rw_gnt", 32'(b_d_gnt), 1);
    nc(); drop(); #1;
    check("rw_addr", b_mem_addr, 32'h80);
    nc(); nc(); nc();
    nc(); mem_rdata = 32'hC0DE;
    nc(); #1;
    check("rw_rvalid", 32'(b_d_rvalid), 1); check("rw_rdata", b_d_rdata, 32'hC0DE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
